// File: rtl/sgd_rd_x_from_memory_pkg.sv
// Shared sizing constants, FSM state type and length helpers for the x load path.
package sgd_rd_x_from_memory_pkg;

  localparam int unsigned ENGINE_NUM         = 8;
  localparam int unsigned NUM_BITS_PER_BANK  = 64;
  localparam int unsigned DIS_X_BIT_DEPTH    = 9;
  localparam int unsigned MAX_BIT_WIDTH_OF_X = 32;

  localparam int unsigned BEAT_W         = 512;
  localparam int unsigned BEATS_PER_WORD = 4;
  localparam int unsigned INNER_W        = $clog2(BEATS_PER_WORD);
  localparam int unsigned X_WORD_W       = NUM_BITS_PER_BANK * MAX_BIT_WIDTH_OF_X;
  localparam int unsigned ENGINE_W       = $clog2(ENGINE_NUM);
  // Features covered by one row across all engines, as a shift amount.
  localparam int unsigned ROW_SHIFT      = $clog2(ENGINE_NUM * NUM_BITS_PER_BANK);
  localparam int unsigned BYTES_PER_ROW  = ENGINE_NUM * X_WORD_W / 8;

  // One-hot encoded load FSM.
  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StCmd  = 4'b0010,
    StData = 4'b0100,
    StDone = 4'b1000
  } state_e;

  // Rows of bank words needed to hold dim features (ceil), 32-bit arithmetic.
  function automatic logic [31:0] calc_rows(input logic [31:0] dim);
    logic [31:0] sum;
    sum = dim + 32'(ENGINE_NUM * NUM_BITS_PER_BANK - 1);
    return sum >> ROW_SHIFT;
  endfunction

  // DMA length in bytes for a given row count.
  function automatic logic [31:0] calc_length(input logic [31:0] rows);
    return rows * 32'(BYTES_PER_ROW);
  endfunction

endpackage

// File: rtl/sgd_rd_x_from_memory_if.sv
// DMA command, read-data stream and x memory write bus of the x load path.
interface sgd_rd_x_from_memory_if;
  import sgd_rd_x_from_memory_pkg::*;

  logic                                    x_data_rd_start;
  logic [63:0]                             x_data_rd_addr;
  logic [31:0]                             x_data_rd_length;
  logic [BEAT_W-1:0]                       x_data_in;
  logic                                    x_data_in_valid;
  logic                                    x_data_in_ready;
  logic [DIS_X_BIT_DEPTH-1:0]              x_mem_wr_addr;
  logic [ENGINE_NUM-1:0][X_WORD_W-1:0]     x_mem_wr_data;
  logic [ENGINE_NUM-1:0]                   x_mem_wr_en;

  // Loader side.
  modport master (
    output x_data_rd_start,
    output x_data_rd_addr,
    output x_data_rd_length,
    input  x_data_in,
    input  x_data_in_valid,
    output x_data_in_ready,
    output x_mem_wr_addr,
    output x_mem_wr_data,
    output x_mem_wr_en
  );

  // DMA engine / memory side.
  modport slave (
    input  x_data_rd_start,
    input  x_data_rd_addr,
    input  x_data_rd_length,
    output x_data_in,
    output x_data_in_valid,
    input  x_data_in_ready,
    input  x_mem_wr_addr,
    input  x_mem_wr_data,
    input  x_mem_wr_en
  );

endinterface

// File: rtl/sgd_x_beat_packer.sv
// Packs 4 read beats into one bank word and writes it to the engines in
// inner-beat -> engine -> row order. Write appears the cycle after the 4th beat.
module sgd_x_beat_packer
  import sgd_rd_x_from_memory_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  input  logic                                beat_fire,
  input  logic [BEAT_W-1:0]                   beat_data,
  input  logic [31:0]                         rows,
  output logic                                last_beat,
  output logic [DIS_X_BIT_DEPTH-1:0]          wr_addr,
  output logic [ENGINE_NUM-1:0][X_WORD_W-1:0] wr_data,
  output logic [ENGINE_NUM-1:0]               wr_en
);

  logic [INNER_W-1:0]         inner_q, inner_d;
  logic [ENGINE_W-1:0]        engine_q, engine_d;
  logic [DIS_X_BIT_DEPTH-1:0] row_q, row_d;
  logic [X_WORD_W-1:0]        word_q, word_d;
  logic [ENGINE_NUM-1:0]      wr_en_q, wr_en_d;
  logic [DIS_X_BIT_DEPTH-1:0] wr_addr_q, wr_addr_d;

  logic word_end;
  logic row_end;

  assign word_end  = beat_fire && (inner_q == INNER_W'(BEATS_PER_WORD - 1));
  assign row_end   = word_end && (engine_q == ENGINE_W'(ENGINE_NUM - 1));
  assign last_beat = row_end && ((32'(row_q) + 32'd1) == rows);

  // Slot/counter advance and write-strobe generation for each accepted beat.
  always_comb begin
    inner_d   = inner_q;
    engine_d  = engine_q;
    row_d     = row_q;
    word_d    = word_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    if (clr) begin
      inner_d  = '0;
      engine_d = '0;
      row_d    = '0;
    end else if (beat_fire) begin
      word_d[32'(inner_q) * BEAT_W +: BEAT_W] = beat_data;
      inner_d = inner_q + INNER_W'(1);
      if (word_end) begin
        wr_en_d   = ENGINE_NUM'(1) << engine_q;
        wr_addr_d = row_q;
        engine_d  = engine_q + ENGINE_W'(1);
        if (row_end) begin
          engine_d = '0;
          row_d    = row_q + DIS_X_BIT_DEPTH'(1);
        end
      end
    end
  end

  // Packer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inner_q   <= '0;
      engine_q  <= '0;
      row_q     <= '0;
      word_q    <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
    end else begin
      inner_q   <= inner_d;
      engine_q  <= engine_d;
      row_q     <= row_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // Every bank sees the same word; the one-hot enable picks the target.
  assign wr_data = {ENGINE_NUM{word_q}};
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: rtl/sgd_rd_x_from_memory.sv
// Loads the model vector x from host memory into the per-engine x memories:
// one DMA read command per load, then 512-bit beats packed into bank words.
module sgd_rd_x_from_memory
  import sgd_rd_x_from_memory_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    started,
  input  logic [63:0]             addr_model,
  input  logic [31:0]             dimension,
  input  logic                    reading_x_en,
  output logic                    reading_x_done,
  output logic [1:0]              error_state,
  output logic [31:0]             x_rd_data_cnt,
  sgd_rd_x_from_memory_if.master  bus
);

  state_e      state_q, state_d;
  logic        en_r1_q, en_r2_q;
  logic [31:0] rows_q;
  logic [31:0] length_q;
  logic [63:0] addr_q;
  logic [1:0]  error_q, error_d;
  logic        zero_done_q;
  logic [31:0] rd_cnt_q;

  logic en_edge;
  logic load_go;
  logic zero_dim;
  logic beat_fire;
  logic last_beat;

  assign en_edge   = en_r1_q & ~en_r2_q;
  assign beat_fire = bus.x_data_in_valid & bus.x_data_in_ready;

  // Next-state logic; a zero-length job completes immediately from idle.
  always_comb begin
    state_d  = state_q;
    load_go  = 1'b0;
    zero_dim = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (started && en_edge) begin
          if (dimension == 32'd0) begin
            zero_dim = 1'b1;
          end else begin
            load_go = 1'b1;
            state_d = StCmd;
          end
        end
      end
      StCmd:  state_d = StData;
      StData: if (last_beat) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sticky error flags: empty job, and a new enable edge while a load is running.
  always_comb begin
    error_d = error_q;
    if (zero_dim) error_d[0] = 1'b1;
    if (en_edge && (state_q != StIdle)) error_d[1] = 1'b1;
  end

  // FSM, enable edge detector and error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      en_r1_q     <= 1'b0;
      en_r2_q     <= 1'b0;
      error_q     <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_r1_q     <= reading_x_en;
      en_r2_q     <= en_r1_q;
      error_q     <= error_d;
      zero_done_q <= zero_dim;
    end
  end

  // Job geometry follows the parameters while started; command address latched per load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_q   <= '0;
      length_q <= '0;
      addr_q   <= '0;
    end else begin
      if (started) begin
        rows_q   <= calc_rows(dimension);
        length_q <= calc_length(calc_rows(dimension));
      end
      if (load_go) addr_q <= addr_model;
    end
  end

  // Debug beat counter, free running since reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
    end else if (beat_fire) begin
      rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  sgd_x_beat_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (state_q == StDone),
    .beat_fire (beat_fire),
    .beat_data (bus.x_data_in),
    .rows      (rows_q),
    .last_beat (last_beat),
    .wr_addr   (bus.x_mem_wr_addr),
    .wr_data   (bus.x_mem_wr_data),
    .wr_en     (bus.x_mem_wr_en)
  );

  assign bus.x_data_rd_start  = (state_q == StCmd);
  assign bus.x_data_rd_addr   = addr_q;
  assign bus.x_data_rd_length = length_q;
  assign bus.x_data_in_ready  = (state_q == StData);

  // Done coincides with the final bank write (or follows an empty job by one cycle).
  assign reading_x_done = (state_q == StDone) | zero_done_q;
  assign error_state    = error_q;
  assign x_rd_data_cnt  = rd_cnt_q;

endmodule

// File: tb/tb_sgd_rd_x_from_memory.sv
// Randomized bench for the x load path against a queue-based write model.
module tb_sgd_rd_x_from_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        started = 1'b0;
  logic [63:0] addr_model = '0;
  logic [31:0] dimension = '0;
  logic        reading_x_en = 1'b0;
  logic        reading_x_done;
  logic [1:0]  error_state;
  logic [31:0] x_rd_data_cnt;

  sgd_rd_x_from_memory_if bus ();

  sgd_rd_x_from_memory dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .started        (started),
    .addr_model     (addr_model),
    .dimension      (dimension),
    .reading_x_en   (reading_x_en),
    .reading_x_done (reading_x_done),
    .error_state    (error_state),
    .x_rd_data_cnt  (x_rd_data_cnt),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]    addr;
    logic [7:0]    en;
    int            eng;
    logic [2047:0] word;
  } wr_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int cmd_cnt = 0;
  int done_cnt = 0;
  bit in_load = 0;
  bit exp_done_write = 0;
  logic [63:0] exp_addr;
  logic [31:0] exp_len;
  logic [511:0] beats[$];
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: command, write and done observation on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_load = 0;
    end else begin
      if (!in_load) check("ready_outside_load", bus.x_data_in_ready, 0);
      if (bus.x_data_rd_start) begin
        cmd_cnt++;
        check("cmd_addr", bus.x_data_rd_addr, exp_addr);
        check("cmd_len", bus.x_data_rd_length, exp_len);
        in_load = 1;
      end
      if (bus.x_data_in_valid && bus.x_data_in_ready) last_acc_cyc = cyc;
      if (bus.x_mem_wr_en != '0) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", bus.x_mem_wr_en, 0);
        end else begin
          wr_t t;
          logic [2047:0] got_w;
          t = exp_q.pop_front();
          got_w = bus.x_mem_wr_data[t.eng];
          check("wr_addr", bus.x_mem_wr_addr, t.addr);
          check("wr_en", bus.x_mem_wr_en, t.en);
          for (int j = 0; j < 4; j++)
            check($sformatf("wr_data%0d", j), got_w[j*512 +: 512], t.word[j*512 +: 512]);
        end
      end
      if (reading_x_done) begin
        done_cnt++;
        if (exp_done_write) begin
          check("done_after_last_beat", cyc - last_acc_cyc, 1);
          check("done_with_write", |bus.x_mem_wr_en, 1);
        end
        in_load = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 0;
    started = 0;
    reading_x_en = 0;
    bus.x_data_in_valid = 0;
    bus.x_data_in = '0;
    repeat (3) tick();
    rst_n = 1;
    cmd_cnt = 0;
    done_cnt = 0;
  endtask

  function automatic int model_rows(input int dim);
    return dim / 512 + ((dim % 512) != 0 ? 1 : 0);
  endfunction

  task automatic gen_beats(input int n);
    logic [511:0] b;
    beats.delete();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 16; k++) b[k*32 +: 32] = $urandom();
      beats.push_back(b);
    end
  endtask

  // Word w goes to engine w%8 at row w/8, built from beats 4w..4w+3 (beat 4w lowest).
  task automatic build_model(input int nwords);
    wr_t t;
    exp_q.delete();
    for (int w = 0; w < nwords; w++) begin
      t.addr = 9'(w / 8);
      t.eng  = w % 8;
      t.en   = 8'(1 << (w % 8));
      for (int j = 0; j < 4; j++) t.word[j*512 +: 512] = beats[w*4 + j];
      exp_q.push_back(t);
    end
  endtask

  task automatic run_beats(input int n, input int gap_pct);
    int idx = 0;
    int guard = 0;
    bit fire = 0;
    while (idx < n && guard < 4000) begin
      @(posedge clk);
      if (fire) idx++;
      guard++;
      #1;
      if (idx < n) begin
        bus.x_data_in = beats[idx];
        bus.x_data_in_valid = ($urandom_range(99) >= gap_pct);
      end else begin
        bus.x_data_in_valid = 0;
      end
      fire = bus.x_data_in_valid && bus.x_data_in_ready;
    end
    bus.x_data_in_valid = 0;
    check("beats_accepted", idx, n);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == 0 && k < 200) begin
      tick();
      k++;
    end
    repeat (4) tick();
  endtask

  task automatic begin_load(input int dim, input logic [63:0] addr);
    tick();
    started = 1;
    dimension = 32'(dim);
    addr_model = addr;
    tick();
    tick();
    reading_x_en = 1;
  endtask

  task automatic do_load(input int dim, input logic [63:0] addr, input int gap, input bit reedge);
    int rows;
    int nbeats;
    rows = model_rows(dim);
    nbeats = rows * 32;
    gen_beats(nbeats);
    build_model(rows * 8);
    exp_addr = addr;
    exp_len = 32'(rows * 8 * 256);
    exp_done_write = 1;
    begin_load(dim, addr);
    fork
      run_beats(nbeats, gap);
      begin
        if (reedge) begin
          repeat (12) tick();
          reading_x_en = 0;
          repeat (2) tick();
          reading_x_en = 1;
        end
      end
    join
    wait_done();
    reading_x_en = 0;
    check($sformatf("cmd_count_dim%0d", dim), cmd_cnt, 1);
    check($sformatf("done_count_dim%0d", dim), done_cnt, 1);
    check($sformatf("writes_left_dim%0d", dim), exp_q.size(), 0);
    check($sformatf("rd_cnt_dim%0d", dim), x_rd_data_cnt, nbeats);
    check($sformatf("error_dim%0d", dim), error_state, reedge ? 2'b10 : 2'b00);
  endtask

  initial begin
    int rdim;
    bus.x_data_in = '0;
    bus.x_data_in_valid = 0;
    exp_addr = '0;
    exp_len = '0;

    do_reset();
    check("rst_done", reading_x_done, 0);
    check("rst_error", error_state, 0);
    check("rst_cmd", bus.x_data_rd_start, 0);
    check("rst_ready", bus.x_data_in_ready, 0);
    check("rst_wr_en", bus.x_mem_wr_en, 0);
    check("rst_cnt", x_rd_data_cnt, 0);
    check("rst_addr", bus.x_data_rd_addr, 0);
    check("rst_len", bus.x_data_rd_length, 0);

    // Single row, full-rate data.
    do_reset();
    do_load(512, 64'h1000, 0, 0);

    // Two rows, full-rate then with random valid gaps.
    do_reset();
    do_load(1000, 64'h2_0000_4000, 0, 0);
    do_reset();
    do_load(1000, 64'h2_0000_4000, 50, 0);

    // Random size.
    rdim = $urandom_range(1, 2000);
    do_reset();
    do_load(rdim, {$urandom(), $urandom()}, 30, 0);

    // Empty job.
    do_reset();
    exp_done_write = 0;
    exp_q.delete();
    begin_load(0, 64'h3000);
    repeat (8) tick();
    reading_x_en = 0;
    check("zero_cmd_count", cmd_cnt, 0);
    check("zero_done_count", done_cnt, 1);
    check("zero_error", error_state, 2'b01);
    check("zero_rd_cnt", x_rd_data_cnt, 0);

    // Second enable edge while loading.
    do_reset();
    do_load(1000, 64'h8000, 0, 1);

    // Reset after 10 beats, then a fresh load.
    do_reset();
    gen_beats(64);
    build_model(2);
    exp_addr = 64'h5000;
    exp_len = 32'd4096;
    exp_done_write = 1;
    begin_load(1000, 64'h5000);
    run_beats(10, 0);
    rst_n = 0;
    started = 0;
    reading_x_en = 0;
    repeat (3) tick();
    rst_n = 1;
    check("abort_writes_left", exp_q.size(), 0);
    check("abort_done", done_cnt, 0);
    cmd_cnt = 0;
    done_cnt = 0;
    repeat (5) tick();
    check("abort_quiet_wr", bus.x_mem_wr_en, 0);
    do_load(512, 64'h1000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
